// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared frame-format types and helpers for the UART transmit path.
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {LEN5, LEN6, LEN7, LEN8} data_len_e;
  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;
  function automatic logic [3:0] data_bits(input data_len_e len);
    return 4'(len) + 4'd5;
  endfunction
endpackage

// File: rtl/device0_tx_driver_if.sv
// device0_tx_driver_if: valid/ready byte write port into the transmitter.
interface device0_tx_driver_if #(parameter int DATA_WIDTH_MAX = 8);
  logic                      wr_valid;
  logic [DATA_WIDTH_MAX-1:0] wr_data;
  logic                      wr_ready;
  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy level; no push bypass when full.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_ptr_q];
  assign level = level_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/device0_tx_driver.sv
// device0_tx_driver: FIFO-buffered UART transmitter with per-frame latched format and baud divider.
module device0_tx_driver
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH_MAX = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DIV_WIDTH-1:0]               cfg_baud_div,
  input  logic [1:0]                         cfg_data_len,
  input  logic                               cfg_parity_en,
  input  logic                               cfg_parity_odd,
  input  logic                               cfg_stop2,
  device0_tx_driver_if.slave                 wr,
  output logic                               tx,
  output logic                               busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  logic [DATA_WIDTH_MAX-1:0] fifo_dout, shift_q, mask;
  logic [DIV_WIDTH-1:0] reload, cnt_q, div_q;
  logic [2:0] bit_q;
  logic fifo_full, fifo_empty, start, bit_end, frame_end, last_data;
  logic stop2_q, stop_q, par_bit_q, tx_q;
  tx_state_e state_q;
  data_len_e len_q;
  parity_e par_q;
  uart_tx_fifo #(.WIDTH(DATA_WIDTH_MAX), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(wr.wr_valid),
    .pop(start),
    .din(wr.wr_data),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );
  assign wr.wr_ready = !fifo_full;
  assign reload = cfg_baud_div == '0 ? '0 : cfg_baud_div - DIV_WIDTH'(1);
  assign mask = ~({DATA_WIDTH_MAX{1'b1}} << data_bits(data_len_e'(cfg_data_len)));
  assign bit_end = cnt_q == '0;
  assign last_data = {1'b0, bit_q} == data_bits(len_q) - 4'd1;
  // second stop bit is tracked by stop_q so frame_end fires only on the very last stop clock
  assign frame_end = state_q == STOP && bit_end && (!stop2_q || stop_q);
  assign start = (state_q == IDLE || frame_end) && !fifo_empty;
  assign tx = tx_q;
  assign tx_done = frame_end;
  assign busy = state_q != IDLE || !fifo_empty;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      len_q <= LEN8;
      par_q <= NONE;
      stop2_q <= 1'b0;
      stop_q <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q <= 1'b1;
    end else if (start) begin
      state_q <= START;
      tx_q <= 1'b0;
      cnt_q <= reload;
      div_q <= reload;
      bit_q <= '0;
      shift_q <= fifo_dout & mask;
      len_q <= data_len_e'(cfg_data_len);
      par_q <= cfg_parity_en ? (cfg_parity_odd ? ODD : EVEN) : NONE;
      par_bit_q <= ^(fifo_dout & mask) ^ cfg_parity_odd;
      stop2_q <= cfg_stop2;
      stop_q <= 1'b0;
    end else if (state_q != IDLE) begin
      cnt_q <= bit_end ? div_q : cnt_q - DIV_WIDTH'(1);
      if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          DATA: begin
            if (last_data) begin
              state_q <= par_q == NONE ? STOP : PARITY;
              tx_q <= par_q == NONE ? 1'b1 : par_bit_q;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end
          default: begin
            if (frame_end) state_q <= IDLE;
            else stop_q <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_device0_tx_driver.sv
// tb_device0_tx_driver: per-cycle comparison of the transmitter against a frame-waveform reference model.
module tb_device0_tx_driver;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [15:0] cfg_baud_div;
  logic [1:0] cfg_data_len;
  logic cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic tx, busy, tx_done;
  logic [2:0] fifo_level;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  bit wave[$];
  device0_tx_driver_if wr ();
  device0_tx_driver dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_baud_div(cfg_baud_div),
    .cfg_data_len(cfg_data_len),
    .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2),
    .wr(wr),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done),
    .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // the model's wave queue holds one tx value per remaining clock of the frame on the line
  task automatic check_all();
    check("tx", 32'(wave.size() != 0 ? wave[0] : 1'b1), 32'(tx));
    check("tx_done", 32'(tx_done), 32'(wave.size() == 1));
    check("busy", 32'(busy), 32'(wave.size() != 0 || mq.size() != 0));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("wr_ready", 32'(wr.wr_ready), 32'(mq.size() < 4));
  endtask
  function automatic void load_frame(input logic [7:0] d);
    int n = int'(cfg_data_len) + 5;
    int dv = cfg_baud_div == 0 ? 1 : int'(cfg_baud_div);
    bit bits[$];
    bit p = cfg_parity_odd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (cfg_parity_en) bits.push_back(p);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (dv) wave.push_back(bits[i]);
  endfunction
  task automatic tick();
    bit had = mq.size() != 0;
    bit full = mq.size() == 4;
    if (reset_n) begin
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && had) load_frame(mq.pop_front());
      if (wr.wr_valid && !full) mq.push_back(wr.wr_data);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic set_cfg(input int div, input int len, input bit pe, input bit po, input bit s2);
    cfg_baud_div = 16'(div);
    cfg_data_len = 2'(len);
    cfg_parity_en = pe;
    cfg_parity_odd = po;
    cfg_stop2 = s2;
  endtask
  task automatic push(input logic [7:0] d);
    bit acc;
    wr.wr_valid = 1'b1;
    wr.wr_data = d;
    for (int i = 0; i < 5000; i++) begin
      acc = mq.size() < 4;
      tick();
      if (acc) break;
    end
    wr.wr_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20000 && (wave.size() != 0 || mq.size() != 0); i++) tick();
    tick();
  endtask
  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_data = '0;
    set_cfg(4, 3, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1 check_all();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    push(8'hA5);
    drain();
    set_cfg(2, 3, 1, 1, 0);
    push(8'h03);
    drain();
    set_cfg(2, 3, 1, 0, 0);
    push(8'h03);
    drain();
    set_cfg(2, 2, 1, 0, 1);
    push(8'h55);
    drain();
    set_cfg(100, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    drain();
    set_cfg(3, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(8'(8'hC3 + i));
    repeat (38) tick();
    reset_n = 1'b0;
    #1;
    mq.delete();
    wave.delete();
    check_all();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (40) tick();
    set_cfg(0, 0, 0, 0, 0);
    push(8'h1F);
    drain();
    set_cfg(2, 3, 0, 0, 0);
    push(8'hE7);
    push(8'hFF);
    repeat (5) tick();
    cfg_data_len = 2'd0;
    drain();
    for (int it = 0; it < 40; it++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(1, 6)) begin
        push(8'($urandom));
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 3) == 0)
          set_cfg($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
